bsg_counter_dynamic_reload_down: RTL and testbench

Down-counting companion to the dynamic-limit up-counter. Loads a run-time limit through a valid/ready port and counts down to 0 on each enabled cycle. It flags underflow at 0, then reloads, so the period is limit+1 enabled cycles, the same period the up-counter produces. A one-entry shadow register lets software/upstream queue the next period while the current one runs, so reloads need no dead cycles. Used as a programmable tick/timeout source feeding credit and throttle logic.

---
 rtl/bsg_counter_dynamic_reload_down_pkg.sv | 10 +
 rtl/bsg_dff_en_async_reset_n.sv | 24 ++
 rtl/bsg_counter_dynamic_reload_down.sv | 101 ++++++++++
 tb/tb_bsg_counter_dynamic_reload_down.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bsg_counter_dynamic_reload_down_pkg.sv
// Shared types for the dynamic-reload down counter.
// The run state is a single bit so it can live in the generic enable flop.
package bsg_counter_dynamic_reload_down_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_dff_en_async_reset_n.sv
// Width-parameterised enable flop with asynchronous active-low clear.
module bsg_dff_en_async_reset_n #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] r_data;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data <= '0;
        end else if (en_i) begin
            r_data <= data_i;
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_counter_dynamic_reload_down.sv
// Down counter with a run-time limit, a one-entry shadow for the next period,
// and an underflow flag while sitting at zero; period is limit+1 enabled cycles.
module bsg_counter_dynamic_reload_down
    import bsg_counter_dynamic_reload_down_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               limit_v_i,
    input  logic [width_p-1:0] limit_i,
    output logic               limit_ready_o,
    output logic [width_p-1:0] counter_o,
    output logic               underflowed_o,
    output logic               running_o
);

    logic [0:0]         w_state_q;
    logic [0:0]         w_state_d;
    state_e             w_state;
    logic [width_p-1:0] w_counter_q;
    logic [width_p-1:0] w_counter_d;
    logic [width_p-1:0] w_active_q;
    logic [width_p-1:0] w_active_d;
    logic [width_p-1:0] w_shadow_q;
    logic [0:0]         w_shadow_v_q;
    logic [0:0]         w_shadow_v_d;
    logic               w_idle;
    logic               w_run;
    logic               w_zero;
    logic               w_hs;
    logic               w_reload;
    logic               w_counter_en;
    logic               w_active_en;
    logic               w_shadow_en;
    logic               w_shadow_v_en;
    logic               w_state_en;

    assign w_state  = state_e'(w_state_q);
    assign w_idle   = (w_state == IDLE);
    assign w_run    = (w_state == RUN);
    assign w_zero   = (w_counter_q == '0);
    assign w_hs     = limit_v_i & limit_ready_o;
    assign w_reload = w_run & en_i & w_zero;

    // A reload prefers the queued shadow value, then a same-cycle handshake,
    // and otherwise repeats the current period.
    always_comb begin
        w_counter_d = w_active_q;
        if (w_idle) begin
            w_counter_d = limit_i;
        end else if (!w_zero) begin
            w_counter_d = w_counter_q - width_p'(1);
        end else if (w_shadow_v_q[0]) begin
            w_counter_d = w_shadow_q;
        end else if (w_hs) begin
            w_counter_d = limit_i;
        end
    end

    assign w_counter_en  = (w_idle & w_hs) | (w_run & en_i);
    assign w_active_en   = (w_idle & w_hs) | (w_reload & (w_shadow_v_q[0] | w_hs));
    assign w_active_d    = (w_reload & w_shadow_v_q[0]) ? w_shadow_q : limit_i;
    assign w_shadow_en   = w_run & w_hs & ~w_reload;
    assign w_shadow_v_en = w_shadow_en | (w_reload & w_shadow_v_q[0]);
    assign w_shadow_v_d  = w_reload ? 1'b0 : 1'b1;
    assign w_state_en    = w_idle & w_hs;
    assign w_state_d     = RUN;

    bsg_dff_en_async_reset_n #(.width_p(width_p)) u_counter (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(w_counter_en),
        .data_i(w_counter_d), .data_o(w_counter_q)
    );

    bsg_dff_en_async_reset_n #(.width_p(width_p)) u_active (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(w_active_en),
        .data_i(w_active_d), .data_o(w_active_q)
    );

    bsg_dff_en_async_reset_n #(.width_p(width_p)) u_shadow (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(w_shadow_en),
        .data_i(limit_i), .data_o(w_shadow_q)
    );

    bsg_dff_en_async_reset_n #(.width_p(1)) u_shadow_v (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(w_shadow_v_en),
        .data_i(w_shadow_v_d), .data_o(w_shadow_v_q)
    );

    bsg_dff_en_async_reset_n #(.width_p(1)) u_state (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(w_state_en),
        .data_i(w_state_d), .data_o(w_state_q)
    );

    assign limit_ready_o = ~w_shadow_v_q[0];
    assign counter_o     = w_counter_q;
    assign running_o     = w_run;
    assign underflowed_o = w_run & w_zero;

endmodule

// File: tb/tb_bsg_counter_dynamic_reload_down.sv
// Directed bench: each driven cycle pushes its hand-computed expected outputs,
// and a monitor compares them just after the following rising edge.
module tb_bsg_counter_dynamic_reload_down;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         en_i = 1'b0;
    logic         limit_v_i = 1'b0;
    logic [W-1:0] limit_i = '0;
    logic         limit_ready_o;
    logic [W-1:0] counter_o;
    logic         underflowed_o;
    logic         running_o;

    typedef struct {
        int    cnt;
        bit    uf;
        bit    run;
        bit    rdy;
        string tag;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    bsg_counter_dynamic_reload_down #(.width_p(W)) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .en_i(en_i),
        .limit_v_i(limit_v_i),
        .limit_i(limit_i),
        .limit_ready_o(limit_ready_o),
        .counter_o(counter_o),
        .underflowed_o(underflowed_o),
        .running_o(running_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input exp_t e);
        total++;
        if (counter_o !== W'(e.cnt) || underflowed_o !== e.uf ||
            running_o !== e.run || limit_ready_o !== e.rdy) begin
            bad++;
            $display("[TB] FAIL %s: got cnt=%0d uf=%b run=%b rdy=%b, want cnt=%0d uf=%b run=%b rdy=%b",
                     e.tag, counter_o, underflowed_o, running_o, limit_ready_o,
                     e.cnt, e.uf, e.run, e.rdy);
        end
    endtask

    // Monitor: outputs after each rising edge are checked against the queue head.
    always @(posedge clk_i) begin
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input bit en, input bit v, input int lim,
                                 input int cnt, input bit uf, input bit run,
                                 input bit rdy, input string tag);
        exp_t e;
        @(negedge clk_i);
        en_i      = en;
        limit_v_i = v;
        limit_i   = W'(lim);
        e.cnt = cnt; e.uf = uf; e.run = run; e.rdy = rdy; e.tag = tag;
        expQ.push_back(e);
        @(posedge clk_i);
    endtask

    initial begin
        exp_t r;
        r.cnt = 0; r.uf = 0; r.run = 0; r.rdy = 1; r.tag = "reset";
        #3;
        checkOutput(r);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Limit 3, free running
        applyStimulus(0, 1, 3, 3, 0, 1, 1, "t1 load");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t1 c2");
        applyStimulus(1, 0, 0, 1, 0, 1, 1, "t1 c1");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t1 c0");
        applyStimulus(1, 0, 0, 3, 0, 1, 1, "t1 reload3");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t1 c2b");
        applyStimulus(1, 0, 0, 1, 0, 1, 1, "t1 c1b");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t1 c0b");
        // Handshake on the reload cycle with empty shadow
        applyStimulus(1, 1, 5, 5, 0, 1, 1, "hs at zero 5");
        applyStimulus(1, 0, 0, 4, 0, 1, 1, "t2 c4");
        // Shadow load of 2 at count 4
        applyStimulus(1, 1, 2, 3, 0, 1, 0, "t2 shadow");
        applyStimulus(1, 1, 9, 2, 0, 1, 0, "t2 blocked");
        applyStimulus(1, 0, 0, 1, 0, 1, 0, "t2 c1");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, "t2 c0");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t2 take shadow");
        applyStimulus(1, 0, 0, 1, 0, 1, 1, "t2 c1b");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t2 c0b");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t2 reuse 2");
        // Handshake 7 exactly at zero
        applyStimulus(1, 0, 0, 1, 0, 1, 1, "t3 c1");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t3 c0");
        applyStimulus(1, 1, 7, 7, 0, 1, 1, "t3 hs7");
        applyStimulus(1, 0, 0, 6, 0, 1, 1, "t3 c6");
        for (int i = 5; i >= 1; i--) begin
            applyStimulus(1, 0, 0, i, 0, 1, 1, "t3 down");
        end
        // Hold at 1 with en low while shadow takes 2
        applyStimulus(0, 1, 2, 1, 0, 1, 0, "t5 shadow hold");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 1, 0, "t5 hold");
        end
        applyStimulus(1, 0, 0, 0, 1, 1, 0, "t5 c0");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, "t5 uf no en");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t5 reload2");
        // Limit 0
        applyStimulus(1, 0, 0, 1, 0, 1, 1, "t4 c1");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t4 c0");
        applyStimulus(1, 1, 0, 0, 1, 1, 1, "t4 load0");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t4 en1");
        applyStimulus(0, 0, 0, 0, 1, 1, 1, "t4 en0");
        applyStimulus(1, 0, 0, 0, 1, 1, 1, "t4 en1b");
        applyStimulus(0, 0, 0, 0, 1, 1, 1, "t4 en0b");
        // Counter 9 with shadow full, then async reset
        applyStimulus(1, 1, 9, 9, 0, 1, 1, "t6 load9");
        applyStimulus(0, 1, 4, 9, 0, 1, 0, "t6 shadow");
        @(negedge clk_i);
        limit_v_i = 1'b0;
        #2;
        reset_n_i = 1'b0;
        #1;
        r.tag = "async reset";
        checkOutput(r);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 1, "t6 idle a");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, "t6 idle b");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, "t6 idle c");
        applyStimulus(0, 1, 3, 3, 0, 1, 1, "t6 reload after");
        applyStimulus(1, 0, 0, 2, 0, 1, 1, "t6 c2");

        repeat (3) @(posedge clk_i);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
